// File: rtl/mb8_loader.sv
// mb8_loader: byte-stream bootloader and bus master for the 8-bit memory port.
// Frame: A5, A2, A1, A0, L1, L0, N payload bytes, checksum C.
// The frame is good when (sum of payload + C) mod 256 == 0.
// Optional read-back verify: define EFORTH1_LOADER_VERIFY_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | hunt for the 0xA5 sync byte, other bytes discarded
// ADR2  | address bit 16 (byte[7:1] must be zero, else abort)
// ADR1  | address bits 15:8
// ADR0  | address bits 7:0
// LEN1  | length high byte
// LEN0  | length low byte, zero length skips to CSUM
// DATA  | accept one payload byte
// WR    | one-cycle write strobe, then bump address / remaining count
// VRD   | (verify) present the same address for read
// VCK   | (verify) compare read data to the byte just written
// CSUM  | accept checksum byte
// DONE  | report result for one cycle
module mb8_loader #(
    parameter int AW = 17,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic [AW-1:0] ai,
    output logic [7:0]    vi,
    output logic          we,
    input  logic [7:0]    vo,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    sum
);

    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [3:0] {
        IDLE,
        ADR2,
        ADR1,
        ADR0,
        LEN1,
        LEN0,
        DATA,
        WR,
`ifdef EFORTH1_LOADER_VERIFY_EN
        VRD,
        VCK,
`endif
        CSUM,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            live_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   ai_q;
    logic [LW-1:0]   rem_q;
    logic [7:0]      vi_q;
    logic [7:0]      sum_q;
    logic            err_q;
    logic            xfer;
    logic [7:0]      csum_tot;
    logic [LW-1:0]   len_full;

`ifndef EFORTH1_LOADER_VERIFY_EN
    logic            unused_vo;
    assign unused_vo = ^vo;
`endif

    assign xfer     = rx_valid & rx_ready;
    assign csum_tot = sum_q + rx_data;
    assign len_full = {rem_q[LW-1:8], rx_data};

    assign ai  = ai_q;
    assign vi  = vi_q;
    assign sum = sum_q;
    assign err = err_q;

    // Byte-accepting states; live_q holds ready low until the first clock out of reset.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            IDLE, ADR2, ADR1, ADR0, LEN1, LEN0, DATA, CSUM: rx_ready = live_q;
            default:                                       rx_ready = 1'b0;
        endcase
    end

    // State register; reset returns to IDLE at once so we drops asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && rx_data == SYNC) state_d = ADR2;
            end
            ADR2: begin
                if (xfer) state_d = (rx_data[7:1] != 7'd0) ? IDLE : ADR1;
            end
            ADR1: begin
                if (xfer) state_d = ADR0;
            end
            ADR0: begin
                if (xfer) state_d = LEN1;
            end
            LEN1: begin
                if (xfer) state_d = LEN0;
            end
            LEN0: begin
                if (xfer) state_d = (len_full == '0) ? CSUM : DATA;
            end
            DATA: begin
                if (xfer) state_d = WR;
            end
            WR: begin
                we = 1'b1;
`ifdef EFORTH1_LOADER_VERIFY_EN
                state_d = VRD;
`else
                // rem_q still holds the count before this byte is retired
                state_d = (rem_q == LW'(1)) ? CSUM : DATA;
`endif
            end
`ifdef EFORTH1_LOADER_VERIFY_EN
            VRD: begin
                state_d = VCK;
            end
            VCK: begin
                state_d = (rem_q == '0) ? CSUM : DATA;
            end
`endif
            CSUM: begin
                if (xfer) state_d = DONE;
            end
            DONE: begin
                done    = ~err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: header capture, payload latch, address/length counters, sum and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            addr_q <= '0;
            ai_q   <= '0;
            rem_q  <= '0;
            vi_q   <= '0;
            sum_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (xfer && rx_data == SYNC) begin
                        err_q <= 1'b0;
                        sum_q <= '0;
                    end
                end
                ADR2: begin
                    if (xfer) begin
                        if (rx_data[7:1] != 7'd0) err_q <= 1'b1;
                        else addr_q[AW-1] <= rx_data[0];
                    end
                end
                ADR1: begin
                    if (xfer) addr_q[AW-2 -: 8] <= rx_data;
                end
                ADR0: begin
                    if (xfer) addr_q[7:0] <= rx_data;
                end
                LEN1: begin
                    if (xfer) rem_q[LW-1:8] <= rx_data;
                end
                LEN0: begin
                    if (xfer) rem_q[7:0] <= rx_data;
                end
                DATA: begin
                    // ai only moves here so it holds steady outside WR/VRD
                    if (xfer) begin
                        vi_q  <= rx_data;
                        sum_q <= sum_q + rx_data;
                        ai_q  <= addr_q;
                    end
                end
                WR: begin
                    addr_q <= addr_q + AW'(1);
                    rem_q  <= rem_q - LW'(1);
                end
`ifdef EFORTH1_LOADER_VERIFY_EN
                VCK: begin
                    // a read-back mismatch spoils the frame but the load carries on
                    if (vo != vi_q) err_q <= 1'b1;
                end
`endif
                CSUM: begin
                    if (xfer && csum_tot != 8'd0) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mb8_loader.sv
// Testbench for mb8_loader: directed and random frames against a frame-level model.
module tb_mb8_loader;

    localparam int AW = 17;
    localparam int LW = 16;
    localparam int MEMSZ = 1 << AW;

`ifdef EFORTH1_LOADER_VERIFY_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic [AW-1:0] ai;
    logic [7:0]    vi;
    logic          we;
    logic [7:0]    vo;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    sum;

    mb8_loader #(.AW(AW), .LW(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .ai       (ai),
        .vi       (vi),
        .we       (we),
        .vo       (vo),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sum      (sum)
    );

    always #5 clk = ~clk;

    // memory slave, write log and protocol monitor
    logic [7:0]    mem [0:MEMSZ-1];
    logic [AW-1:0] wr_a [$];
    logic [7:0]    wr_d [$];
    int            done_cnt = 0;
    int            viol = 0;
    int            cyc = 0;
    int            corrupt_addr = -1;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            mem[ai] = vi;
            wr_a.push_back(ai);
            wr_d.push_back(vi);
            if (rx_ready !== 1'b0) viol++;
        end
        if (done === 1'b1) done_cnt++;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        vo  <= mem[ai] ^ ((corrupt_addr == int'(ai)) ? 8'hFF : 8'h00);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // frame-level reference model
    logic [7:0] frame_q [$];
    int         exp_wa [$];
    int         exp_wd [$];
    int         exp_sum, exp_err, exp_abort, sync_idx;

    task automatic model_frame();
        int a, n, s, c, wa;
        exp_wa.delete();
        exp_wd.delete();
        exp_sum = 0; exp_err = 0; exp_abort = 0;
        sync_idx = 0;
        while (frame_q[sync_idx] != 8'hA5) sync_idx++;
        s = sync_idx;
        if (int'(frame_q[s+1]) > 1) begin
            exp_abort = 1;
            exp_err = 1;
            return;
        end
        a = int'(frame_q[s+1]) * 65536 + int'(frame_q[s+2]) * 256 + int'(frame_q[s+3]);
        n = int'(frame_q[s+4]) * 256 + int'(frame_q[s+5]);
        for (int i = 0; i < n; i++) begin
            wa = (a + i) % MEMSZ;
            exp_wa.push_back(wa);
            exp_wd.push_back(int'(frame_q[s+6+i]));
            exp_sum = (exp_sum + int'(frame_q[s+6+i])) % 256;
`ifdef EFORTH1_LOADER_VERIFY_EN
            if (wa == corrupt_addr) exp_err = 1;
`endif
        end
        c = int'(frame_q[s+6+n]);
        if ((exp_sum + c) % 256 != 0) exp_err = 1;
    endtask

    // present one byte, optionally after idle gaps; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int g, w;
        g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
        @(negedge clk);
        repeat (g) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        while (rx_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rx_ready_wait", 32'(w < 50), 32'd1);
        if (w < 50) @(posedge clk);
    endtask

    task automatic run_frame(input int gapmax, input string tag);
        int base_w, base_d, last, t_sync, exp_done;
        model_frame();
        exp_done = (exp_err == 0 && exp_abort == 0) ? 1 : 0;
        base_w = wr_a.size();
        base_d = done_cnt;
        last   = frame_q.size() - 1;
        t_sync = 0;
        for (int i = 0; i <= last; i++) begin
            send_byte(frame_q[i], gapmax);
            #1;
            if (i < sync_idx) check({tag, "_garbage_busy"}, 32'(busy), 32'd0);
            if (i == sync_idx) begin
                t_sync = cyc;
                check({tag, "_sync_err"}, 32'(err), 32'd0);
                check({tag, "_sync_sum"}, 32'(sum), 32'd0);
                check({tag, "_sync_busy"}, 32'(busy), 32'd1);
            end
            if (exp_abort != 0 && i == sync_idx + 1) begin
                rx_valid = 1'b0;
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                check({tag, "_abort_err"}, 32'(err), 32'd1);
                check({tag, "_abort_sum"}, 32'(sum), 32'd0);
                break;
            end
            if (i == last) begin
                rx_valid = 1'b0;
                if (gapmax == 0)
                    check({tag, "_cycles"}, 32'(cyc - t_sync), 32'(6 + exp_wa.size() * STEP));
                check({tag, "_done"}, 32'(done), 32'(exp_done));
                check({tag, "_err"}, 32'(err), 32'(exp_err));
                check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
                check({tag, "_done_busy"}, 32'(busy), 32'd1);
                check({tag, "_done_ready"}, 32'(rx_ready), 32'd0);
                @(posedge clk);
                #1;
                check({tag, "_end_busy"}, 32'(busy), 32'd0);
                check({tag, "_end_done"}, 32'(done), 32'd0);
            end
        end
        check({tag, "_nwrites"}, 32'(wr_a.size() - base_w), 32'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size(); i++) begin
            if (base_w + i < wr_a.size()) begin
                check({tag, "_waddr"}, 32'(wr_a[base_w+i]), 32'(exp_wa[i]));
                check({tag, "_wdata"}, 32'(wr_d[base_w+i]), 32'(exp_wd[i]));
            end
        end
        check({tag, "_ndone"}, 32'(done_cnt - base_d), 32'(exp_done));
    endtask

    task automatic build_random();
        int g, n, s, a1, a0, a2;
        logic [7:0] b;
        frame_q.delete();
        g = $urandom_range(0, 2);
        repeat (g) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            frame_q.push_back(b);
        end
        frame_q.push_back(8'hA5);
        if ($urandom_range(0, 7) == 0) begin
            frame_q.push_back(8'($urandom_range(2, 255)));
            return;
        end
        a2 = $urandom_range(0, 1);
        a1 = $urandom_range(0, 255);
        a0 = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0) begin
            a2 = 1; a1 = 255; a0 = $urandom_range(252, 255);
        end
        n = $urandom_range(0, 5);
        frame_q.push_back(8'(a2));
        frame_q.push_back(8'(a1));
        frame_q.push_back(8'(a0));
        frame_q.push_back(8'h00);
        frame_q.push_back(8'(n));
        s = 0;
        repeat (n) begin
            b = 8'($urandom_range(0, 255));
            s = (s + int'(b)) % 256;
            frame_q.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) frame_q.push_back(8'($urandom_range(0, 255)));
        else frame_q.push_back(8'((256 - s) % 256));
    endtask

    int base_w;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_ai", 32'(ai), 32'd0);
        check("rst_vi", 32'(vi), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rx_ready", 32'(rx_ready), 32'd1);

        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        run_frame(0, "good3");
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        run_frame(0, "badsum");
        frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h02};
        run_frame(0, "badadr");
        frame_q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h9B};
        run_frame(0, "wrap");
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        run_frame(0, "zero");

        for (int k = 0; k < 25; k++) begin
            build_random();
            run_frame((k % 3 == 0) ? 0 : 2, "rand");
        end

`ifdef EFORTH1_LOADER_VERIFY_EN
        corrupt_addr = 'h101;
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        run_frame(0, "verify");
        corrupt_addr = -1;
`endif

        // reset in the middle of a payload write
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h44, 8'h55};
        base_w = wr_a.size();
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 0);
        #1;
        check("midrst_we_before", 32'(we), 32'd1);
        check("midrst_ai_before", 32'(ai), 32'h201);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(rx_ready), 32'd0);
        check("midrst_ai", 32'(ai), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_nwrites", 32'(wr_a.size() - base_w), 32'd1);
        if (wr_a.size() > base_w) begin
            check("midrst_waddr", 32'(wr_a[base_w]), 32'h200);
            check("midrst_wdata", 32'(wr_d[base_w]), 32'h44);
        end
        @(posedge clk);
        #1;
        check("midrst_ready_back", 32'(rx_ready), 32'd1);

        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        run_frame(2, "recover");

        check("we_with_ready", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
